bit_serial_add_ctrl: RTL and testbench

- Sequencer that time-shares one external single-bit full adder to perform a WIDTH-bit add or subtract, one bit per clock, LSB first.
- Accepts operands via valid/ready and drives the full adder's iA/iB/iCarry inputs.
- Captures the adder's oSum/oCarry and returns the result, carry-out and signed overflow via valid/ready.
- Sits between the accelerator's operand issue logic and the shared full_adder instance; lowest-area add path.

---
 rtl/bit_serial_add_ctrl.sv | 120 ++++++++++++
 tb/tb_bit_serial_add_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial add/subtract sequencer driving one shared external full adder, LSB first.
// Define BIT_SERIAL_ABORT_EN to add the iAbort port for cancelling an in-flight operation.
module bit_serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iValid,
    output logic             oReady,
    input  logic [WIDTH-1:0] iOpA,
    input  logic [WIDTH-1:0] iOpB,
    input  logic             iSub,
    output logic             oFaA,
    output logic             oFaB,
    output logic             oFaCin,
`ifdef BIT_SERIAL_ABORT_EN
    input  logic             iAbort,
`endif
    input  logic             iFaSum,
    input  logic             iFaCout,
    output logic             oValid,
    input  logic             iReady,
    output logic [WIDTH-1:0] oResult,
    output logic             oCarry,
    output logic             oOverflow
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic [CW-1:0]    count;
    logic             last_bit;
    logic             abort;

`ifdef BIT_SERIAL_ABORT_EN
    assign abort = iAbort;
`else
    assign abort = 1'b0;
`endif

    // Explicit terminal compare keeps non-power-of-two widths correct.
    assign last_bit = (count == CW'(WIDTH - 1));

    assign oReady  = (state == IDLE);
    assign oFaA    = (state == RUN) & op_a[0];
    assign oFaB    = (state == RUN) & op_b[0];
    assign oFaCin  = (state == RUN) & carry;
    assign oResult = result;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            result    <= '0;
            carry     <= 1'b0;
            count     <= '0;
            oValid    <= 1'b0;
            oCarry    <= 1'b0;
            oOverflow <= 1'b0;
        end else if (abort) begin
            // Abort also blocks acceptance while idle.
            if (state != IDLE) begin
                state     <= IDLE;
                op_a      <= '0;
                op_b      <= '0;
                result    <= '0;
                carry     <= 1'b0;
                count     <= '0;
                oValid    <= 1'b0;
                oCarry    <= 1'b0;
                oOverflow <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (iValid) begin
                        op_a  <= iOpA;
                        op_b  <= iOpB ^ {WIDTH{iSub}};
                        carry <= iSub;
                        count <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    result <= {iFaSum, result[WIDTH-1:1]};
                    op_a   <= op_a >> 1;
                    op_b   <= op_b >> 1;
                    carry  <= iFaCout;
                    count  <= count + 1'b1;
                    if (last_bit) begin
                        // carry still holds the carry into the MSB here
                        oCarry    <= iFaCout;
                        oOverflow <= carry ^ iFaCout;
                        oValid    <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (iReady) begin
                        oValid <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Scoreboard bench for bit_serial_add_ctrl with a behavioural full adder in the loop.
module tb_bit_serial_add_ctrl;

    localparam int unsigned W   = 8;
    localparam int          TMO = 4 * W + 8;

    typedef struct packed {
        logic [W-1:0] res;
        logic         carry;
        logic         ovf;
    } result_t;

    logic         iClk, iRst, iValid, oReady, iSub;
    logic [W-1:0] iOpA, iOpB, oResult;
    logic         oFaA, oFaB, oFaCin, iFaSum, iFaCout;
    logic         oValid, iReady, oCarry, oOverflow;
    logic         iAbort;

    result_t      sb_q[$];
    int           n_checks = 0;
    int           n_errors = 0;
    logic         bp_next  = 1'b0;
    logic [W-1:0] nxt_a, nxt_b;
    logic         nxt_sub;

    bit_serial_add_ctrl #(.WIDTH(W)) dut (
        .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady),
        .iOpA(iOpA), .iOpB(iOpB), .iSub(iSub),
        .oFaA(oFaA), .oFaB(oFaB), .oFaCin(oFaCin),
`ifdef BIT_SERIAL_ABORT_EN
        .iAbort(iAbort),
`endif
        .iFaSum(iFaSum), .iFaCout(iFaCout),
        .oValid(oValid), .iReady(iReady),
        .oResult(oResult), .oCarry(oCarry), .oOverflow(oOverflow)
    );

    // The shared full adder
    assign iFaSum  = oFaA ^ oFaB ^ oFaCin;
    assign iFaCout = (oFaA & oFaB) | (oFaA & oFaCin) | (oFaB & oFaCin);

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, oReady, 1);
        check({tag, "_valid"}, oValid, 0);
        check({tag, "_result"}, oResult, 0);
        check({tag, "_flags"}, {oCarry, oOverflow}, 0);
        check({tag, "_fa"}, {oFaA, oFaB, oFaCin}, 0);
    endtask

    // Drives one request starting at a negedge; returns at a negedge with the DUT idle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input int hold);
        logic [W-1:0] bb, sa, sbs, sc, exp_cin, ref_res;
        logic         c, early;
        logic [W:0]   sum;
        result_t      e, got;
        int           n;
        bb  = b ^ {W{sub}};
        sum = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
        e.res   = sum[W-1:0];
        e.carry = sum[W];
        e.ovf   = (a[W-1] == bb[W-1]) && (e.res[W-1] != a[W-1]);
        c = sub;
        for (int k = 0; k < W; k++) begin
            exp_cin[k] = c;
            c = (a[k] & bb[k]) | (a[k] & c) | (bb[k] & c);
        end

        iOpA = a; iOpB = b; iSub = sub; iValid = 1'b1;
        n = 0;
        while (!oReady && n < TMO) begin
            @(negedge iClk);
            n++;
        end
        check("accept_wait", n < TMO, 1);
        if (n >= TMO) begin
            iValid = 1'b0;
            return;
        end
        sb_q.push_back(e);
        @(posedge iClk);
        @(negedge iClk);
        // Scramble operands: the in-flight operation must not see them
        iValid = 1'b0; iOpA = W'($urandom); iOpB = W'($urandom); iSub = 1'($urandom);

        early = 1'b0;
        for (int k = 0; k < W; k++) begin
            sa[k] = oFaA; sbs[k] = oFaB; sc[k] = oFaCin;
            early |= oValid;
            @(negedge iClk);
        end
        check("early_valid", early, 0);
        check("fa_a_stream", sa, a);
        check("fa_b_stream", sbs, bb);
        check("fa_cin_stream", sc, exp_cin);
        check("latency_valid", oValid, 1);

        ref_res = oResult;
        for (int h = 0; h < hold; h++) begin
            if (bp_next) begin
                iOpA = nxt_a; iOpB = nxt_b; iSub = nxt_sub; iValid = 1'b1;
            end
            check("hold_stable",
                  {oValid, oResult, oReady, oFaA, oFaB, oFaCin},
                  {1'b1, ref_res, 1'b0, 3'b000});
            @(negedge iClk);
        end

        if (sb_q.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            got = {oResult, oCarry, oOverflow};
            e = sb_q.pop_front();
            check("result", got.res, e.res);
            check("carry", got.carry, e.carry);
            check("overflow", got.ovf, e.ovf);
        end
        iReady = 1'b1;
        @(posedge iClk);
        @(negedge iClk);
        iReady = 1'b0;
        check("valid_drop", oValid, 0);
        check("ready_idle", oReady, 1);
    endtask

    initial begin
        iRst = 1'b1; iValid = 1'b0; iReady = 1'b0; iAbort = 1'b0;
        iOpA = '0; iOpB = '0; iSub = 1'b0;
        nxt_a = '0; nxt_b = '0; nxt_sub = 1'b0;
        #3;
        check_idle_outputs("reset");
        @(negedge iClk);
        @(negedge iClk);
        iRst = 1'b0;

        run_op(8'h3C, 8'h19, 1'b0, 0);
        run_op(8'h05, 8'h07, 1'b1, 0);
        run_op(8'h7F, 8'h01, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 1);
        run_op(8'h80, 8'h01, 1'b1, 0);

        // Backpressure with the next request already pending
        nxt_a = 8'hA5; nxt_b = 8'h5A; nxt_sub = 1'b1;
        bp_next = 1'b1;
        run_op(8'h12, 8'h34, 1'b0, 5);
        bp_next = 1'b0;
        run_op(nxt_a, nxt_b, nxt_sub, 0);

        // Reset in the middle of RUN
        iOpA = 8'h6B; iOpB = 8'h2D; iSub = 1'b0; iValid = 1'b1;
        @(posedge iClk);
        @(negedge iClk);
        iValid = 1'b0;
        repeat (4) @(negedge iClk);
        #2 iRst = 1'b1;
        #1 check_idle_outputs("midrun_reset");
        @(negedge iClk);
        iRst = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < W + 2; k++) begin
                seen |= oValid;
                @(negedge iClk);
            end
            check("no_valid_after_reset", seen, 0);
        end
        run_op(8'h6B, 8'h2D, 1'b0, 0);

`ifdef BIT_SERIAL_ABORT_EN
        iOpA = 8'h44; iOpB = 8'h33; iSub = 1'b0; iValid = 1'b1;
        @(posedge iClk);
        @(negedge iClk);
        iValid = 1'b0;
        repeat (2) @(negedge iClk);
        iAbort = 1'b1;
        @(posedge iClk);
        @(negedge iClk);
        iAbort = 1'b0;
        check_idle_outputs("abort");
        begin
            logic seen;
            seen = 1'b0;
            for (int k = 0; k < W + 2; k++) begin
                seen |= oValid;
                @(negedge iClk);
            end
            check("no_valid_after_abort", seen, 0);
        end
        // Abort in IDLE blocks acceptance
        iValid = 1'b1; iAbort = 1'b1;
        @(posedge iClk);
        @(negedge iClk);
        iValid = 1'b0; iAbort = 1'b0;
        check("abort_idle_priority", {oReady, oFaA, oFaB, oFaCin}, 4'b1000);
        run_op(8'h01, 8'h01, 1'b0, 0);
`endif

        for (int i = 0; i < 6; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end

        check("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
